// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU FSM state type and
// request legality helpers used by the load/store unit.
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} lsu_state_t;

    // Stores only have signed-size encodings; the unsigned ones are load-only.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
//   funct3     : access size / signedness
//   offset     : byte offset within the word (addr[1:0])
//   rd_word    : word read from memory (load path)
//   merge_base : previously read word to be patched (sub-word store path)
//   wdata      : store data, low byte/half used for SB/SH
//   load_data  : extracted and sign/zero-extended load result
//   merge_data : word to write back to memory
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rd_word,
    input  logic [31:0] merge_base,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (offset)
            2'd0: byte_sel = rd_word[7:0];
            2'd1: byte_sel = rd_word[15:8];
            2'd2: byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        merge_data = merge_base;
        case (funct3)
            F3_B: merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
            F3_H: merge_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit driving a word-addressed data memory.
//   req_*  : RV32I load/store request from execute (valid/ready)
//   rsp_*  : extended load data or error flag back to the core (valid/ready)
//   mem_*  : word index, write strobe/data, combinational read data
// Sub-word stores are performed as read (ACCESS) then merged write (WRITE).
module lsu_mem_master
    import rv32i_pkg::*;
#(
    parameter int unsigned MEM_AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data
);

    lsu_state_t  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_ok;
    logic        in_range;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    // Word index must fit in the implemented memory.
    assign in_range = (req_addr[31:2] >> MEM_AW) == 30'd0;
    assign req_ok   = f3_legal(req_we, req_funct3) &&
                      !f3_misaligned(req_funct3, req_addr[1:0]) && in_range;

    lsu_align u_align (
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .rd_word    (mem_rd_data),
        .merge_base (buf_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (req_valid) state_d = req_ok ? ACCESS : RESP;
            ACCESS: state_d = (we_q && funct3_q != F3_W) ? WRITE : RESP;
            WRITE:  state_d = RESP;
            RESP:   if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready   = (state_q == IDLE);
        rsp_valid   = (state_q == RESP);
        mem_wr_en   = 1'b0;
        mem_wr_data = 32'd0;
        if (state_q == ACCESS && we_q && funct3_q == F3_W) begin
            mem_wr_en   = 1'b1;
            mem_wr_data = wdata_q;
        end else if (state_q == WRITE) begin
            mem_wr_en   = 1'b1;
            mem_wr_data = merge_data;
        end
    end

    assign mem_addr  = {2'b00, addr_q[31:2]};
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Request/response datapath
    always_comb begin
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        buf_d    = buf_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (state_q == IDLE && req_valid) begin
            we_d     = req_we;
            funct3_d = req_funct3;
            addr_d   = req_addr;
            wdata_d  = req_wdata;
            rdata_d  = 32'd0;
            err_d    = !req_ok;
        end else if (state_q == ACCESS) begin
            if (we_q) begin
                buf_d = mem_rd_data;
            end else begin
                rdata_d = load_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            buf_q    <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            buf_q    <= buf_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule
